// File: rtl/gsim_sweep_scheduler.sv
// gsim_sweep_scheduler: loads b, issues Gauss-Seidel sweeps until limit/convergence, drains, reads x out
module gsim_sweep_scheduler #(
  parameter int N_ELEM   = 16,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 4,
  parameter int MAX_ITER = 70,
  parameter int ITER_W   = 9,
  localparam int IDX_W   = $clog2(N_ELEM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic [DATA_W-1:0] tol,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              load_en,
  output logic              sweep_en,
  output logic [IDX_W-1:0]  idx,
  input  logic              x_new_valid,
  input  logic [DATA_W-1:0] x_new,
  input  logic [DATA_W-1:0] x_old,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [ITER_W-1:0] iter,
  output logic              converged,
  output logic              done
);
  localparam int DR_W = $clog2(PIPE_LAT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d, idx_q, idx_d, res_cnt_q, res_cnt_d, out_idx_q, out_idx_d;
  logic [IDX_W:0] rd_cnt_q, rd_cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d, limit_q, limit_d;
  logic [DATA_W-1:0] tol_q, tol_d, max_q, max_d, delta, mx;
  logic [DATA_W:0] diff, mag;
  logic [DR_W-1:0] drain_q, drain_d;
  logic conv_q, conv_d, out_valid_q, out_valid_d, mon, hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      idx_q       <= '0;
      res_cnt_q   <= '0;
      out_idx_q   <= '0;
      rd_cnt_q    <= '0;
      iter_q      <= '0;
      limit_q     <= '0;
      tol_q       <= '0;
      max_q       <= '0;
      drain_q     <= '0;
      conv_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      idx_q       <= idx_d;
      res_cnt_q   <= res_cnt_d;
      out_idx_q   <= out_idx_d;
      rd_cnt_q    <= rd_cnt_d;
      iter_q      <= iter_d;
      limit_q     <= limit_d;
      tol_q       <= tol_d;
      max_q       <= max_d;
      drain_q     <= drain_d;
      conv_q      <= conv_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    res_cnt_d  = res_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    iter_d     = iter_q;
    limit_d    = limit_q;
    tol_d      = tol_q;
    max_d      = max_q;
    drain_d    = drain_q;
    conv_d     = conv_q;
    b_ready    = state_q == LOAD;
    load_en    = b_valid & b_ready;
    sweep_en   = state_q == RUN;
    rd_en      = state_q == OUTPUT && !rd_cnt_q[IDX_W];
    rd_idx     = rd_cnt_q[IDX_W-1:0];
    out_valid_d = rd_en;
    out_idx_d  = rd_idx;
    // 33-bit signed difference; |diff| only overflows 32 bits in theory, saturate anyway
    diff  = {x_new[DATA_W-1], x_new} - {x_old[DATA_W-1], x_old};
    mag   = diff[DATA_W] ? -diff : diff;
    delta = mag[DATA_W] ? '1 : mag[DATA_W-1:0];
    mx    = delta > max_q ? delta : max_q;
    mon   = x_new_valid && (state_q == RUN || state_q == DRAIN);
    hit   = mon && res_cnt_q == IDX_W'(N_ELEM - 1) && mx <= tol_q;
    if (mon) begin
      res_cnt_d = res_cnt_q + 1'b1;
      max_d     = res_cnt_q == IDX_W'(N_ELEM - 1) ? '0 : mx;
      conv_d    = conv_q | hit;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d    = LOAD;
        iter_d     = '0;
        conv_d     = 1'b0;
        limit_d    = iter_limit == '0 ? ITER_W'(MAX_ITER) : iter_limit;
        tol_d      = tol;
        load_cnt_d = '0;
        res_cnt_d  = '0;
        max_d      = '0;
      end
      LOAD: if (load_en) begin
        load_cnt_d = load_cnt_q + 1'b1;
        if (load_cnt_q == IDX_W'(N_ELEM - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_ELEM - 1)) iter_d = iter_q + 1'b1;
        if ((idx_q == IDX_W'(N_ELEM - 1) && iter_q + ITER_W'(1) == limit_q) || hit) begin
          state_d = DRAIN;
          idx_d   = '0;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DR_W'(PIPE_LAT - 1)) begin
          state_d  = OUTPUT;
          rd_cnt_d = '0;
        end
      end
      OUTPUT: begin
        rd_cnt_d = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
        if (rd_cnt_q[IDX_W]) begin
          state_d  = IDLE;
          rd_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign idx       = idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign iter      = iter_q;
  assign converged = conv_q;
  assign done      = out_valid_q && out_idx_q == IDX_W'(N_ELEM - 1);
endmodule
